wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Shares the single register-file write port between the in-order pipeline write-back and the multi-cycle multiply/divide unit (MDU). It sits between the write-back stage output (`reg_write`, `regdst_out`, `data_to_reg`) and the register file. It buffers MDU results in a small FIFO and drains them into idle write-port cycles. Optionally, it forces a drain slot by stalling the pipeline after bounded starvation, and it publishes a pending-destination mask for the hazard unit.

## Interface
- `DEPTH`, 2: MDU result FIFO entries; power of two, ≥2.
- `STARVE_MAX`, 4: consecutive starved cycles before a forced slot; range 1..15.

- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset; one clock, asynchronous assert, active-low.
- `wb_reg_write` in 1: pipeline write request, from write-back stage `reg_write`.
- `wb_regdst` in 5: pipeline destination register.
- `wb_data` in 32: pipeline write data.
- `mdu_valid` in 1: MDU result valid.
- `mdu_ready` out 1: FIFO can accept; `!full`.
- `mdu_regdst` in 5: MDU destination register.
- `mdu_data` in 32: MDU result.
- `rf_we` out 1: register-file write enable, registered.
- `rf_waddr` out 5: register-file write address, registered.
- `rf_wdata` out 32: register-file write data, registered.
- `pipe_stall` out 1: hold the write-back stage this cycle, combinational from state.
- `pend_mask` out 32: bit n = live FIFO entry targets register n, registered.
- `fifo_count` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- **Enqueue.** An MDU result is enqueued on `mdu_valid && mdu_ready`. A `mdu_regdst==0` result is accepted and then discarded; it never enters the FIFO.
- **Pipeline request.** A pipeline request is effective when `wb_reg_write && wb_regdst!=0`. A write to r0 is ignored and never consumes the port.
- **Grant priority:**
  1. Forced slot (`force_q`=1): grant the FIFO head; `pipe_stall`=1.
  2. Effective pipeline request: grant the pipeline.
  3. FIFO non-empty: grant the FIFO head.
  4. Otherwise: no write.
- **Kill rule.** On a pipeline grant, any FIFO entry already present at that edge whose dst equals `wb_regdst` is marked dead, because the pipeline result is younger. A same-cycle enqueue is not killed.
- **Dead entries.** A dead head is popped in any cycle without using the port, and the same cycle's grant proceeds normally.
- **`pend_mask`.** OR of one-hot dst over live entries after the current edge's enqueue, pop and kill.
- **Starvation counter `starve_q`.**
  - Increments when the FIFO holds a live entry and the pipeline is granted.
  - Clears on any FIFO grant.
  - When `starve_q==STARVE_MAX`, `force_q` sets for exactly one cycle and `starve_q` clears.
  - During a forced cycle the pipeline write is not performed. The write-back stage holds its inputs and presents them again next cycle.
- **Simultaneous enqueue and pop when full.** `mdu_ready` is 0 when full, so a pop never frees space for a same-cycle enqueue.

## Timing
- Grant to register-file write: 1 cycle. `rf_*` reflects the grant of the previous cycle.
- Enqueue to earliest write: 2 cycles (enqueue edge, grant cycle, `rf_*` edge). There is no bypass from `mdu_*` to `rf_*`.
- `mdu_ready` depends only on registered occupancy.
- **Reset values:**
  - `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0
  - `pend_mask`=0, `fifo_count`=0
  - `mdu_ready`=1, `pipe_stall`=0
  - `starve_q`=0, `force_q`=0
- **Reset mid-operation.** All FIFO contents are discarded, with no write-back of buffered results. The MDU must be reset by the same `rst_n`.
- Pointers wrap modulo `DEPTH`. `fifo_count` ranges 0..`DEPTH`.

## Configuration
- `WB_ARB_STARVE_EN` defined: the starvation counter and forced slot behave as described above.
- Undefined: strict pipeline priority.
  - `pipe_stall` is tied to 0.
  - `starve_q` and `force_q` are not present.
  - FIFO entries drain only in cycles with no effective pipeline request.

## Test plan
- **Idle drain.** Reset, then enqueue MDU {r5, 0x1234} with no pipeline writes -> `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0x1234 two cycles after enqueue; `pend_mask` bit 5 is set for exactly the cycles the entry is live.
- **Kill.** Enqueue MDU r7, then a pipeline write to r7 of 0xAA the next cycle -> only one write to r7 (0xAA), the entry is dropped, `pend_mask`[7] clears, and `fifo_count` returns to 0.
- **Full / backpressure.** `DEPTH`=2, continuous pipeline writes, three MDU results offered back-to-back -> `mdu_ready`=0 after two accepts and the third is held until space frees.
- **Starvation (`WB_ARB_STARVE_EN`, `STARVE_MAX`=4).** Continuous pipeline writes with one live MDU entry -> `pipe_stall`=1 on the 5th cycle, the MDU entry is written, and the held pipeline write lands the following cycle.
- **r0 and reset.** MDU r0 and pipeline r0 requests -> never `rf_we`. Then assert `rst_n`=0 with 2 entries buffered -> all outputs go to reset values immediately, and no writes follow deassertion.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single register-file write port between the
// in-order write-back stage and the multi-cycle MDU. MDU results wait in a
// small FIFO and drain into idle port cycles. A younger pipeline write to the
// same register kills any older buffered result for that register.
//
// Optional feature macro: WB_ARB_STARVE_EN
//   defined   - a starvation counter forces a drain slot (and stalls the
//               write-back stage) after STARVE_MAX starved grants.
//   undefined - strict pipeline priority; pipe_stall is tied low.
module wb_port_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wb_reg_write,
    input  logic [4:0]              wb_regdst,
    input  logic [31:0]             wb_data,
    input  logic                    mdu_valid,
    output logic                    mdu_ready,
    input  logic [4:0]              mdu_regdst,
    input  logic [31:0]             mdu_data,
    output logic                    rf_we,
    output logic [4:0]              rf_waddr,
    output logic [31:0]             rf_wdata,
    output logic                    pipe_stall,
    output logic [31:0]             pend_mask,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int PW = $clog2(DEPTH);

    // FIFO storage; live_q marks occupied entries not yet killed
    logic [4:0]       dst_q  [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] live_q, live_nxt;
    logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [PW:0]      count_q, count_nxt;

    logic        pipe_eff, enq, head_live, pop;
    logic        grant_pipe, grant_fifo;
    logic [31:0] mask_nxt;
    logic [4:0]  slot_dst;

`ifdef WB_ARB_STARVE_EN
    logic [3:0] starve_q, starve_nxt;
    logic       force_q;
`endif

    // Full check uses registered occupancy only, so a pop never frees space
    // for a same-cycle enqueue.
    assign mdu_ready  = (count_q != (PW+1)'(DEPTH));
    assign fifo_count = count_q;
    assign pipe_eff   = wb_reg_write && (wb_regdst != 5'd0);
    // r0 results are accepted (handshake completes) but never stored
    assign enq        = mdu_valid && mdu_ready && (mdu_regdst != 5'd0);
    assign head_live  = (count_q != '0) && live_q[rd_ptr_q];

    // Port grant, kill of older same-destination entries, and next FIFO state
    always_comb begin
        grant_pipe = 1'b0;
        grant_fifo = 1'b0;
`ifdef WB_ARB_STARVE_EN
        if (force_q)
            grant_fifo = head_live;
        else
`endif
        if (pipe_eff)
            grant_pipe = 1'b1;
        else
            grant_fifo = head_live;

        // A dead head leaves without using the port; a live head leaves on grant
        pop = (count_q != '0) && (!live_q[rd_ptr_q] || grant_fifo);

        live_nxt = live_q;
        if (grant_pipe) begin
            for (int i = 0; i < DEPTH; i++)
                if (live_q[i] && (dst_q[i] == wb_regdst))
                    live_nxt[i] = 1'b0;
        end
        if (pop)
            live_nxt[rd_ptr_q] = 1'b0;
        // Enqueue lands after the kill so a same-cycle result stays live
        if (enq)
            live_nxt[wr_ptr_q] = 1'b1;

        count_nxt = count_q;
        case ({enq, pop})
            2'b10:   count_nxt = count_q + 1'b1;
            2'b01:   count_nxt = count_q - 1'b1;
            default: count_nxt = count_q;
        endcase

        mask_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_dst = (enq && (wr_ptr_q == PW'(i))) ? mdu_regdst : dst_q[i];
            if (live_nxt[i])
                mask_nxt[slot_dst] = 1'b1;
        end
    end

    // FIFO state, pending mask and registered write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                dst_q[i]  <= '0;
                data_q[i] <= '0;
            end
            live_q    <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            pend_mask <= '0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
        end else begin
            if (enq) begin
                dst_q[wr_ptr_q]  <= mdu_regdst;
                data_q[wr_ptr_q] <= mdu_data;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            live_q    <= live_nxt;
            count_q   <= count_nxt;
            pend_mask <= mask_nxt;
            rf_we     <= grant_pipe || grant_fifo;
            if (grant_pipe) begin
                rf_waddr <= wb_regdst;
                rf_wdata <= wb_data;
            end else if (grant_fifo) begin
                rf_waddr <= dst_q[rd_ptr_q];
                rf_wdata <= data_q[rd_ptr_q];
            end else begin
                rf_waddr <= '0;
                rf_wdata <= '0;
            end
        end
    end

`ifdef WB_ARB_STARVE_EN
    // Count pipeline grants that bypass a live entry; any drain or forced slot resets
    always_comb begin
        starve_nxt = starve_q;
        if (force_q || grant_fifo)
            starve_nxt = '0;
        else if (grant_pipe && (|live_q))
            starve_nxt = starve_q + 4'd1;
    end

    // Reaching the limit raises a one-cycle forced drain slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
            force_q  <= 1'b0;
        end else begin
            starve_q <= starve_nxt;
            force_q  <= (starve_nxt == 4'(STARVE_MAX));
        end
    end

    assign pipe_stall = force_q;
`else
    assign pipe_stall = 1'b0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: a vector table for single-cycle
// behaviour plus hand-written starvation and mid-operation reset sequences.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_reg_write;
    logic [4:0]  wb_regdst;
    logic [31:0] wb_data;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_regdst;
    logic [31:0] mdu_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        pipe_stall;
    logic [31:0] pend_mask;
    logic [1:0]  fifo_count;

    int checks   = 0;
    int failures = 0;

    wb_port_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_reg_write(wb_reg_write), .wb_regdst(wb_regdst), .wb_data(wb_data),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
        .mdu_regdst(mdu_regdst), .mdu_data(mdu_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pipe_stall(pipe_stall), .pend_mask(pend_mask), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  dst;
        logic [31:0] dat;
        logic        mv;
        logic [4:0]  md;
        logic [31:0] mdat;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_rdy;
        logic [31:0] e_pend;
        logic [1:0]  e_cnt;
    } vec_t;

    vec_t vt[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] dst, input logic [31:0] dat,
                         input logic mv, input logic [4:0] md, input logic [31:0] mdat);
        wb_reg_write = we;
        wb_regdst    = dst;
        wb_data      = dat;
        mdu_valid    = mv;
        mdu_regdst   = md;
        mdu_data     = mdat;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic we, input logic [4:0] addr,
                              input logic [31:0] data, input logic rdy, input logic [31:0] pend,
                              input logic [1:0] cnt, input logic stall);
        chk({tag, ".rf_we"},      32'(rf_we),      32'(we));
        chk({tag, ".rf_waddr"},   32'(rf_waddr),   32'(addr));
        chk({tag, ".rf_wdata"},   rf_wdata,        data);
        chk({tag, ".mdu_ready"},  32'(mdu_ready),  32'(rdy));
        chk({tag, ".pend_mask"},  pend_mask,       pend);
        chk({tag, ".fifo_count"}, 32'(fifo_count), 32'(cnt));
        chk({tag, ".pipe_stall"}, 32'(pipe_stall), 32'(stall));
    endtask

    initial begin
        // Each row: inputs held for one cycle, outputs expected just after that edge
        //          we dst  dat        mv md  mdat        e_we addr data       rdy pend         cnt
        // idle drain
        vt[0]  = '{0, 0,  32'h0,     1, 5,  32'h1234,  0, 0,  32'h0,     1, 32'h0000_0020, 1};
        vt[1]  = '{0, 0,  32'h0,     0, 0,  32'h0,     1, 5,  32'h1234,  1, 32'h0,         0};
        vt[2]  = '{0, 0,  32'h0,     0, 0,  32'h0,     0, 0,  32'h0,     1, 32'h0,         0};
        // r0 on both sides: never a write, nothing buffered
        vt[3]  = '{1, 0,  32'hBEEF,  1, 0,  32'hDEAD,  0, 0,  32'h0,     1, 32'h0,         0};
        vt[4]  = '{0, 0,  32'h0,     0, 0,  32'h0,     0, 0,  32'h0,     1, 32'h0,         0};
        // backpressure: pipeline busy, three MDU results offered
        vt[5]  = '{1, 20, 32'h100,   1, 1,  32'h11,    1, 20, 32'h100,   1, 32'h0000_0002, 1};
        vt[6]  = '{1, 21, 32'h101,   1, 2,  32'h22,    1, 21, 32'h101,   0, 32'h0000_0006, 2};
        vt[7]  = '{1, 22, 32'h102,   1, 3,  32'h33,    1, 22, 32'h102,   0, 32'h0000_0006, 2};
        vt[8]  = '{0, 0,  32'h0,     1, 3,  32'h33,    1, 1,  32'h11,    1, 32'h0000_0004, 1};
        vt[9]  = '{0, 0,  32'h0,     1, 3,  32'h33,    1, 2,  32'h22,    1, 32'h0000_0008, 1};
        vt[10] = '{0, 0,  32'h0,     0, 0,  32'h0,     1, 3,  32'h33,    1, 32'h0,         0};
        vt[11] = '{0, 0,  32'h0,     0, 0,  32'h0,     0, 0,  32'h0,     1, 32'h0,         0};
        // kill: younger pipeline write to r7 drops buffered r7
        vt[12] = '{0, 0,  32'h0,     1, 7,  32'h77,    0, 0,  32'h0,     1, 32'h0000_0080, 1};
        vt[13] = '{1, 7,  32'hAA,    0, 0,  32'h0,     1, 7,  32'hAA,    1, 32'h0,         1};
        vt[14] = '{0, 0,  32'h0,     0, 0,  32'h0,     0, 0,  32'h0,     1, 32'h0,         0};
        // same-cycle enqueue to the pipeline's destination survives
        vt[15] = '{1, 9,  32'h99,    1, 9,  32'h999,   1, 9,  32'h99,    1, 32'h0000_0200, 1};
        vt[16] = '{0, 0,  32'h0,     0, 0,  32'h0,     1, 9,  32'h999,   1, 32'h0,         0};
        vt[17] = '{0, 0,  32'h0,     0, 0,  32'h0,     0, 0,  32'h0,     1, 32'h0,         0};

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        expect_out("reset", 0, 0, 0, 1, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            drive(vt[i].we, vt[i].dst, vt[i].dat, vt[i].mv, vt[i].md, vt[i].mdat);
            tick();
            expect_out($sformatf("v%0d", i), vt[i].e_we, vt[i].e_addr, vt[i].e_data,
                       vt[i].e_rdy, vt[i].e_pend, vt[i].e_cnt, 1'b0);
        end

        // Continuous pipeline writes with one buffered MDU result
        drive(1, 10, 32'h500, 1, 4, 32'h44);
        tick();
        expect_out("st0", 1, 10, 32'h500, 1, 32'h10, 1, 0);
`ifdef WB_ARB_STARVE_EN
        for (int k = 1; k <= 4; k++) begin
            drive(1, 11, 32'h600 + 32'(k), 0, 0, 0);
            tick();
            expect_out($sformatf("st%0d", k), 1, 11, 32'h600 + 32'(k), 1, 32'h10, 1, (k == 4));
        end
        // Stalled cycle: forced drain of r4, write-back holds its r11 write
        drive(1, 11, 32'h605, 0, 0, 0);
        tick();
        expect_out("st5", 1, 4, 32'h44, 1, 0, 0, 0);
        tick();
        expect_out("st6", 1, 11, 32'h605, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        expect_out("st7", 0, 0, 0, 1, 0, 0, 0);
`else
        // Strict priority: the entry waits for as long as the pipeline writes
        for (int k = 1; k <= 6; k++) begin
            drive(1, 11, 32'h600 + 32'(k), 0, 0, 0);
            tick();
            expect_out($sformatf("st%0d", k), 1, 11, 32'h600 + 32'(k), 1, 32'h10, 1, 0);
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        expect_out("st7", 1, 4, 32'h44, 1, 0, 0, 0);
        tick();
        expect_out("st8", 0, 0, 0, 1, 0, 0, 0);
`endif

        // Reset with two buffered results: nothing is written back afterwards
        drive(1, 12, 32'h700, 1, 5, 32'h55);
        tick();
        expect_out("rs0", 1, 12, 32'h700, 1, 32'h20, 1, 0);
        drive(1, 13, 32'h701, 1, 6, 32'h66);
        tick();
        expect_out("rs1", 1, 13, 32'h701, 0, 32'h60, 2, 0);
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        expect_out("rs_async", 0, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            expect_out($sformatf("rs_after%0d", k), 0, 0, 0, 1, 0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
